// File: rtl/btn_debounce_repeat_if.sv
// Button conditioner bundle: async tick/button inputs in, debounced levels, press pulses and sample strobe out.
interface btn_debounce_repeat_if #(
    parameter int NUM_BTN = 4
);
    logic               tick_in;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_pulse;
    logic               sample_tick;

    modport master (
        output tick_in,
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  sample_tick
    );

    modport slave (
        input  tick_in,
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output sample_tick
    );
endinterface

// File: rtl/btn_debounce_repeat.sv
// Debounces NUM_BTN raw buttons on a strobe derived from the 20 Hz divided clock and emits press pulses.
// Auto-repeat while held is built only when BTN_AUTOREPEAT_EN is defined; otherwise one pulse per press.
module btn_debounce_repeat #(
    parameter int NUM_BTN        = 4,
    parameter int STABLE_SAMPLES = 2,
    parameter int REPEAT_DELAY   = 10,
    parameter int REPEAT_PERIOD  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    btn_debounce_repeat_if.slave bus
);
    localparam logic [3:0] STABLE_C = 4'(STABLE_SAMPLES);

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
    localparam logic [7:0] DELAY_C  = 8'(REPEAT_DELAY);
    localparam logic [7:0] PERIOD_C = 8'(REPEAT_PERIOD);
    logic [NUM_BTN-1:0][7:0] hc_q, hc_d;
`else
    typedef enum logic {IDLE, HELD} state_t;
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{8'(REPEAT_DELAY), 8'(REPEAT_PERIOD)};
`endif

    logic                    tick_p0, tick_p1, tick_p2, smp_vld_p3;
    logic [NUM_BTN-1:0]      btn_p0, btn_p1;
    logic [NUM_BTN-1:0][3:0] cnt_q, cnt_d;
    logic [NUM_BTN-1:0]      level_q, rise_flip, fall_flip;
    logic [NUM_BTN-1:0]      pulse_q, pulse_d;
    state_t [NUM_BTN-1:0]    state_q, state_d;

    // Stages p0..p3: synchronise the tick and buttons, register the rising-edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_p0    <= 1'b0;
            tick_p1    <= 1'b0;
            tick_p2    <= 1'b0;
            smp_vld_p3 <= 1'b0;
            btn_p0     <= '0;
            btn_p1     <= '0;
        end else begin
            tick_p0    <= bus.tick_in;
            tick_p1    <= tick_p0;
            tick_p2    <= tick_p1;
            smp_vld_p3 <= tick_p1 & ~tick_p2;
            btn_p0     <= bus.btn_raw;
            btn_p1     <= btn_p0;
        end
    end

    // Stage p3 -> p4: debounce decision on the sample taken in the strobe cycle
    always_comb begin
        cnt_d     = cnt_q;
        rise_flip = '0;
        fall_flip = '0;
        if (smp_vld_p3) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_p1[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + 4'd1 == STABLE_C) begin
                    cnt_d[i]     = '0;
                    rise_flip[i] = ~level_q[i];
                    fall_flip[i] = level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) state_q[i] <= IDLE;
            cnt_q   <= '0;
            level_q <= '0;
            pulse_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
            hc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_q ^ (rise_flip | fall_flip);
            pulse_q <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
            hc_q    <= hc_d;
`endif
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // A release flip takes priority over a repeat falling due on the same tick
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (rise_flip[i]) begin
                        state_d[i] = HELD;
                        hc_d[i]    = '0;
                    end
                end
                HELD: begin
                    if (fall_flip[i]) begin
                        state_d[i] = IDLE;
                        hc_d[i]    = '0;
                    end else if (smp_vld_p3) begin
                        if (hc_q[i] + 8'd1 == DELAY_C) begin
                            state_d[i] = REPEAT;
                            hc_d[i]    = '0;
                        end else begin
                            hc_d[i] = hc_q[i] + 8'd1;
                        end
                    end
                end
                REPEAT: begin
                    if (fall_flip[i]) begin
                        state_d[i] = IDLE;
                        hc_d[i]    = '0;
                    end else if (smp_vld_p3) begin
                        if (hc_q[i] + 8'd1 == PERIOD_C) hc_d[i] = '0;
                        else                            hc_d[i] = hc_q[i] + 8'd1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    hc_d[i]    = '0;
                end
            endcase
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            case (state_q[i])
                IDLE:    pulse_d[i] = rise_flip[i];
                HELD:    pulse_d[i] = smp_vld_p3 & ~fall_flip[i] & (hc_q[i] + 8'd1 == DELAY_C);
                REPEAT:  pulse_d[i] = smp_vld_p3 & ~fall_flip[i] & (hc_q[i] + 8'd1 == PERIOD_C);
                default: pulse_d[i] = 1'b0;
            endcase
        end
    end
`else
    // Without auto-repeat HELD simply waits for the release flip
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (state_q[i] == IDLE) begin
                if (rise_flip[i]) state_d[i] = HELD;
            end else begin
                if (fall_flip[i]) state_d[i] = IDLE;
            end
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            pulse_d[i] = (state_q[i] == IDLE) & rise_flip[i];
        end
    end
`endif

    assign bus.btn_level   = level_q;
    assign bus.press_pulse = pulse_q;
    assign bus.sample_tick = smp_vld_p3;
endmodule
